// File: rtl/mux4_rr_arbiter_if.sv
// mux4_rr_arbiter_if: request/data/grant bundle and output stream of the
// four-requester mux arbiter. The master side belongs to the requesters and
// the downstream sink; the slave side belongs to the arbiter.
interface mux4_rr_arbiter_if #(
   parameter int WIDTH = 32
);
   logic [3:0]       req;
   logic [WIDTH-1:0] in1;
   logic [WIDTH-1:0] in2;
   logic [WIDTH-1:0] in3;
   logic [WIDTH-1:0] in4;
   logic [3:0]       gnt;
   logic [1:0]       sel;
   logic [WIDTH-1:0] out;
   logic             out_valid;
   logic             out_ready;

   modport master (
      output req, in1, in2, in3, in4, out_ready,
      input  gnt, sel, out, out_valid
   );

   modport slave (
      input  req, in1, in2, in3, in4, out_ready,
      output gnt, sel, out, out_valid
   );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin arbiter in front of a 4:1 WIDTH-bit mux.
// One requester wins per transfer; its word is registered into a single
// output stage with a valid/ready handshake. The output stage is a two-state
// FSM (EMPTY/FULL) whose state is out_valid itself.
// Optional build macro MUX4_ARB_PRIO0_EN: requester 0 gets strict priority
// and its grants leave the round-robin pointer untouched.
module mux4_rr_arbiter #(
   parameter int WIDTH     = 32,
   parameter int PTR_RESET = 0
) (
   input  logic               clk,
   input  logic               rst_n,
   mux4_rr_arbiter_if.slave   bus
);

   localparam logic [1:0] PTR_INIT = PTR_RESET[1:0];

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] out_q, out_d;
   logic [1:0]       sel_q, sel_d;
   logic [1:0]       ptr_q, ptr_d;

   logic             load;
   logic             has_win;
   logic             ptr_upd;
   logic [1:0]       win;
   logic [3:0]       req_rot;
   logic [3:0]       gnt_c;
   logic [1:0]       cand_idx [4];
   logic [WIDTH-1:0] in_arr   [4];

   assign in_arr[0] = bus.in1;
   assign in_arr[1] = bus.in2;
   assign in_arr[2] = bus.in3;
   assign in_arr[3] = bus.in4;

   // The stage can take a new word when it is empty or being drained.
   assign load = (state_q == ST_EMPTY) || bus.out_ready;

   // Rotate the request vector so that position 0 is the pointer's requester.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_rot
         assign cand_idx[gi] = ptr_q + 2'(gi);
         assign req_rot[gi]  = bus.req[cand_idx[gi]];
      end
   endgenerate

   // Winner selection; suppressed while stalled or while reset is held.
   always_comb begin
      has_win = 1'b0;
      win     = 2'd0;
      ptr_upd = 1'b0;
      if (load && rst_n) begin
         // Scan from the far end so the nearest set bit to ptr wins last.
         for (int i = 3; i >= 0; i--) begin
            if (req_rot[i]) begin
               has_win = 1'b1;
               win     = cand_idx[i];
            end
         end
         ptr_upd = has_win;
`ifdef MUX4_ARB_PRIO0_EN
         if (bus.req[0]) begin
            win     = 2'd0;
            ptr_upd = 1'b0;
         end
`endif
      end
   end

   generate
      for (gi = 0; gi < 4; gi++) begin : g_gnt
         assign gnt_c[gi] = has_win && (win == 2'(gi));
      end
   endgenerate

   // Next-state of the output stage, select and pointer.
   always_comb begin
      state_d = state_q;
      out_d   = out_q;
      sel_d   = sel_q;
      ptr_d   = ptr_q;
      case (state_q)
         ST_EMPTY: if (has_win) state_d = ST_FULL;
         ST_FULL:  if (bus.out_ready) state_d = has_win ? ST_FULL : ST_EMPTY;
         default:  state_d = ST_EMPTY;
      endcase
      if (has_win) begin
         out_d = in_arr[win];
         sel_d = win;
      end
      if (ptr_upd) begin
         ptr_d = win + 2'd1;
      end
   end

   // State registers; reset clears the stage immediately, dropping any held word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_EMPTY;
         out_q   <= '0;
         sel_q   <= 2'd0;
         ptr_q   <= PTR_INIT;
      end else begin
         state_q <= state_d;
         out_q   <= out_d;
         sel_q   <= sel_d;
         ptr_q   <= ptr_d;
      end
   end

   assign bus.gnt       = gnt_c;
   assign bus.sel       = sel_q;
   assign bus.out       = out_q;
   assign bus.out_valid = (state_q == ST_FULL);

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb_mux4_rr_arbiter: directed test of mux4_rr_arbiter with hand-computed
// expectations. Inputs change 1 time unit after a rising edge; gnt is checked
// 1 unit later, registered outputs 1 unit after the next rising edge.
module tb_mux4_rr_arbiter;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   int   n_total = 0;
   int   n_bad   = 0;

   mux4_rr_arbiter_if #(.WIDTH(32)) bus_if ();

   mux4_rr_arbiter #(.WIDTH(32), .PTR_RESET(0)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end else begin
         $display("ok   %s = %0h", tag, got);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_out(input string tag, input logic v, input logic [31:0] o, input logic [1:0] s);
      chk({tag, ".valid"}, 32'(bus_if.out_valid), 32'(v));
      chk({tag, ".out"},   bus_if.out, o);
      chk({tag, ".sel"},   32'(bus_if.sel), 32'(s));
   endtask

   int rot_gnt [5];
   int rot_out [5];
   int mac_gnt [8];
   int mac_out [8];
   int wrap_out [2];
   int idle_out;
   int idle_sel;

   initial begin
`ifdef MUX4_ARB_PRIO0_EN
      rot_gnt  = '{1, 1, 1, 1, 1};
      rot_out  = '{1, 1, 1, 1, 1};
      mac_gnt  = '{1, 1, 1, 1, 1, 1, 1, 1};
      mac_out  = '{1, 1, 1, 1, 1, 1, 1, 1};
      wrap_out = '{1, 1};
      idle_out = 1;
      idle_sel = 0;
`else
      rot_gnt  = '{1, 2, 4, 8, 1};
      rot_out  = '{1, 2, 3, 4, 1};
      mac_gnt  = '{1, 2, 4, 8, 1, 2, 4, 8};
      mac_out  = '{1, 2, 3, 4, 1, 2, 3, 4};
      wrap_out = '{1, 4};
      idle_out = 4;
      idle_sel = 3;
`endif
      bus_if.req       = 4'b1111;
      bus_if.in1       = 32'd1;
      bus_if.in2       = 32'd2;
      bus_if.in3       = 32'd3;
      bus_if.in4       = 32'd4;
      bus_if.out_ready = 1'b1;

      // Reset asserted asynchronously, before any clock edge.
      #1 rst_n = 1'b0;
      #2;
      chk_out("rst", 1'b0, 32'd0, 2'd0);
      chk("rst.gnt", 32'(bus_if.gnt), 32'd0);
      tick();
      rst_n      = 1'b1;
      bus_if.req = 4'b0000;
      #1 chk("idle.gnt", 32'(bus_if.gnt), 32'd0);
      tick();
      chk_out("idle", 1'b0, 32'd0, 2'd0);

      // Full rotation with all four requesting.
      bus_if.req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         #1 chk($sformatf("rot%0d.gnt", k), 32'(bus_if.gnt), 32'(rot_gnt[k]));
         tick();
         chk_out($sformatf("rot%0d", k), 1'b1, 32'(rot_out[k]), 2'(rot_out[k] - 1));
      end

      // Drain, then backpressure with a single requester.
      bus_if.req = 4'b0000;
      tick();
      chk_out("drain", 1'b0, 32'(rot_out[4]), 2'(rot_out[4] - 1));
      bus_if.req       = 4'b0010;
      bus_if.out_ready = 1'b0;
      #1 chk("bp.gnt0", 32'(bus_if.gnt), 32'h2);
      tick();
      chk_out("bp.load", 1'b1, 32'd2, 2'd1);
      #1 chk("bp.gnt_stall", 32'(bus_if.gnt), 32'd0);
      tick();
      chk_out("bp.hold", 1'b1, 32'd2, 2'd1);
      bus_if.in2       = 32'h22;
      bus_if.out_ready = 1'b1;
      #1 chk("bp.gnt1", 32'(bus_if.gnt), 32'h2);
      tick();
      chk_out("bp.next", 1'b1, 32'h22, 2'd1);
      bus_if.in2 = 32'd2;

      // Pointer wrap 3 -> 0, then skip over idle requesters.
      bus_if.req = 4'b1000;
      #1 chk("wrap.gnt", 32'(bus_if.gnt), 32'h8);
      tick();
      chk_out("wrap", 1'b1, 32'd4, 2'd3);
      bus_if.req = 4'b1001;
      for (int k = 0; k < 2; k++) begin
         #1 chk($sformatf("skip%0d.gnt", k), 32'(bus_if.gnt), 32'(1 << (wrap_out[k] - 1)));
         tick();
         chk_out($sformatf("skip%0d", k), 1'b1, 32'(wrap_out[k]), 2'(wrap_out[k] - 1));
      end
      bus_if.req = 4'b0000;
      #1 chk("gone.gnt", 32'(bus_if.gnt), 32'd0);
      tick();
      chk_out("gone", 1'b0, 32'(idle_out), 2'(idle_sel));

      // Reset while a word is held under backpressure.
      bus_if.req       = 4'b0100;
      bus_if.out_ready = 1'b0;
      tick();
      chk_out("held", 1'b1, 32'd3, 2'd2);
      bus_if.req = 4'b1111;
      rst_n      = 1'b0;
      #1;
      chk_out("midrst", 1'b0, 32'd0, 2'd0);
      chk("midrst.gnt", 32'(bus_if.gnt), 32'd0);
      tick();
      chk_out("midrst.clk", 1'b0, 32'd0, 2'd0);
      chk("midrst.gnt_clk", 32'(bus_if.gnt), 32'd0);
      rst_n            = 1'b1;
      bus_if.out_ready = 1'b1;

      // Eight sustained cycles from the reset pointer.
      for (int k = 0; k < 8; k++) begin
         #1 chk($sformatf("run%0d.gnt", k), 32'(bus_if.gnt), 32'(mac_gnt[k]));
         tick();
         chk_out($sformatf("run%0d", k), 1'b1, 32'(mac_out[k]), 2'(mac_out[k] - 1));
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/mux4_rr_arbiter.md
Name: mux4_rr_arbiter

Overview:
- Round-robin arbiter and sequencer that shares the 4:1 32-bit mux datapath between four requesters.
- Picks one requester per transfer and drives the mux select.
- Registers the selected word into an output stage with a valid/ready handshake.
- Sits in front of the 4:1 mux and owns its `sel`; downstream logic sees a single valid/ready stream.

Parameters:
- WIDTH, 32, data width of each requester input and of `out`.
- PTR_RESET, 0, round-robin pointer value after reset (0..3).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- req  input  4  per-requester valid; bit i = requester i (in1..in4) has data.
- in1  input  WIDTH  requester 0 data.
- in2  input  WIDTH  requester 1 data.
- in3  input  WIDTH  requester 2 data.
- in4  input  WIDTH  requester 3 data.
- gnt  output  4  one-hot accept, combinational; transfer from requester i at edge where req[i]&gnt[i].
- sel  output  2  registered select of the word currently in the output stage.
- out  output  WIDTH  registered output data.
- out_valid  output  1  output stage holds a word.
- out_ready  input  1  downstream accepts `out` at edge where out_valid&out_ready.

Behaviour:
- Reset (rst_n=0, takes effect immediately, without a clock edge):
  - out_valid=0, out=0, sel=0.
  - Round-robin pointer ptr=PTR_RESET.
  - gnt=0 while reset is held.
- Load condition: load = !out_valid || out_ready.
- Arbitration (combinational, only when load=1):
  - Search req starting at index ptr, then ptr+1, ptr+2, ptr+3 (mod 4).
  - The first set bit is the winner w; gnt = one-hot(w).
  - If load=0 or req=0, gnt=0.
- On a clock edge with load=1:
  - Winner exists: out <= in(w+1), sel <= w, out_valid <= 1, ptr <= (w+1) mod 4.
  - No winner: out_valid <= 0; out, sel and ptr hold.
- On a clock edge with load=0 (stalled): out, sel, out_valid and ptr hold; gnt=0.
- Two-state FSM, encoded by out_valid:
  - EMPTY -> FULL on any grant.
  - FULL -> FULL on out_ready with a grant (back-to-back, no bubble).
  - FULL -> EMPTY on out_ready with req=0.
  - FULL -> FULL (stall) on !out_ready.
- Latency and throughput:
  - req[i] high before edge k with load=1 -> out_valid=1 with that data after edge k (1 cycle).
  - Sustained throughput is 1 word/cycle while out_ready=1.
- Fairness: a continuously requesting port is granted within 4 transfers.
- Boundary conditions:
  - Winner dropping req in the same cycle it is granted: it is not granted and arbitration re-evaluates; gnt is combinational from the current req.
  - Single requester: granted every load cycle, and ptr keeps advancing past it.
  - Pointer wrap: 3 -> 0.
  - Reset mid-transfer: the held word is discarded and not delivered; no gnt is issued while reset is held.
- Width rule: sel is exactly 2 bits, and out is exactly WIDTH bits, with no extension.

Optional Feature:
- Macro: MUX4_ARB_PRIO0_EN.
- Defined: requester 0 has strict priority. If req[0]=1 and load=1, requester 0 wins and ptr is not updated; otherwise round-robin runs as above.
- Undefined: pure round-robin as specified, with all requesters treated equally.

Test Plan:
- Reset: rst_n=0 with req=4'b1111 -> out_valid=0, out=0, sel=0, gnt=0 immediately without a clock. After release with req=0 -> outputs stay at 0.
- Full rotation: in1..in4=1,2,3,4, req=4'b1111, out_ready=1 -> out=1,2,3,4,1 on consecutive cycles; sel=0,1,2,3,0; gnt=0001,0010,0100,1000,0001.
- Backpressure: req=4'b0010, out_ready=0 -> gnt=0010 for one cycle, then out_valid=1, out=2, sel=1 held with gnt=0. Raising out_ready -> word 2 is consumed and the next grant goes to requester 1 again.
- Pointer wrap and skip: grant requester 3 first (ptr becomes 0), then req=4'b1001 -> outputs 1 then 4. Go idle (req=0, out_ready=1) -> out_valid drops to 0 while out=4 and sel=3 hold.
- Reset mid-operation: out_valid=1, out=3, out_ready=0, then pulse rst_n=0 -> out_valid=0 without a clock. After release, req=4'b1111 -> first out=1 (ptr=PTR_RESET=0).
- Macro: req=4'b1111, out_ready=1 for 8 cycles -> with MUX4_ARB_PRIO0_EN, out=1 every cycle; without it, out=1,2,3,4,1,2,3,4.
